// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types used by the write-back stage: source select,
// load sizing, write-back control bundle and FSM states.
package riscv_pkg;

  typedef enum logic [1:0] {
    ALUtoRF = 2'd0,
    MEMtoRF = 2'd1,
    IMMtoRF = 2'd2,
    PCtoRF  = 2'd3
  } wb_src_e;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2
  } ld_size_e;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

  typedef struct packed {
    wb_src_e    src;
    logic [4:0] rd;
    logic       regwrite;
    logic       is_load;
    ld_size_e   ld_size;
    logic       ld_unsigned;
  } WB_ctrl;

  // Halfwords need an even address, words need a 4-byte aligned one.
  function automatic logic ld_misaligned(input ld_size_e size, input logic [1:0] lsb);
    return ((size == LD_H) && lsb[0]) || ((size == LD_W) && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane select and sign/zero extension of the raw
// data-memory word according to access size and address low bits.
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      lsb,
  input  ld_size_e        size,
  input  logic            uns,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = raw[{lsb, 3'b000} +: 8];
  assign lane_h = raw[{lsb[1], 4'b0000} +: 16];

  always_comb begin
    data = raw;
    case (size)
      LD_B:    data = {{(XLEN-8){~uns & lane_b[7]}}, lane_b};
      LD_H:    data = {{(XLEN-16){~uns & lane_h[15]}}, lane_h};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered RISC-V write-back stage: source mux, variable-latency load wait,
// sub-word alignment and register-file write port. Optional load watchdog
// enabled by defining WB_TIMEOUT_EN.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid_i,
  output logic            wb_ready_o,
  input  WB_ctrl          wbctrl_i,
  input  logic [XLEN-1:0] alu_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pcplus4_i,
  input  logic [1:0]      addr_lsb_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  input  logic            dmem_rvalid_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            misalign_o,
  output logic            timeout_o
);

  wb_state_e       state;
  logic            accept;
  logic [XLEN-1:0] src_data;
  logic [XLEN-1:0] ld_data;
  logic            ld_mis;

  // Only the fields needed to finish the load are held across the wait.
  logic [4:0]      ld_rd;
  logic            ld_regwrite;
  ld_size_e        ld_size;
  logic            ld_uns;
  logic [1:0]      ld_lsb;

  assign wb_ready_o = (state == WB_IDLE);
  assign accept     = mem_valid_i & wb_ready_o;
  assign ld_mis     = ld_misaligned(ld_size, ld_lsb);

  always_comb begin
    src_data = '0;
    case (wbctrl_i.src)
      ALUtoRF: src_data = alu_i;
      IMMtoRF: src_data = imm_i;
      PCtoRF:  src_data = pcplus4_i;
      default: src_data = '0;
    endcase
  end

  load_align #(.XLEN(XLEN)) u_align (
    .raw  (dmem_rdata_i),
    .lsb  (ld_lsb),
    .size (ld_size),
    .uns  (ld_uns),
    .data (ld_data)
  );

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             to_hit;

  assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Held at zero while idle so the first wait cycle counts from 0.
  always_ff @(posedge clk) begin
    if (!rst_n || state == WB_IDLE) to_cnt <= '0;
    else                            to_cnt <= to_cnt + 1'b1;
  end
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_o          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= WB_IDLE;
      ld_rd       <= '0;
      ld_regwrite <= 1'b0;
      ld_size     <= LD_B;
      ld_uns      <= 1'b0;
      ld_lsb      <= '0;
      rf_we_o     <= 1'b0;
      rf_waddr_o  <= '0;
      rf_wdata_o  <= '0;
      misalign_o  <= 1'b0;
`ifdef WB_TIMEOUT_EN
      timeout_o   <= 1'b0;
`endif
    end else begin
      rf_we_o    <= 1'b0;
      misalign_o <= 1'b0;
`ifdef WB_TIMEOUT_EN
      timeout_o  <= 1'b0;
`endif
      case (state)
        WB_IDLE: begin
          if (accept) begin
            if (wbctrl_i.is_load) begin
              ld_rd       <= wbctrl_i.rd;
              ld_regwrite <= wbctrl_i.regwrite;
              ld_size     <= wbctrl_i.ld_size;
              ld_uns      <= wbctrl_i.ld_unsigned;
              ld_lsb      <= addr_lsb_i;
              state       <= WB_WAIT_LOAD;
            end else begin
              rf_we_o    <= wbctrl_i.regwrite & (wbctrl_i.rd != 5'd0);
              rf_waddr_o <= wbctrl_i.rd;
              rf_wdata_o <= src_data;
            end
          end
        end
        WB_WAIT_LOAD: begin
          if (dmem_rvalid_i) begin
            rf_we_o    <= ld_regwrite & (ld_rd != 5'd0) & ~ld_mis;
            rf_waddr_o <= ld_rd;
            rf_wdata_o <= ld_data;
            misalign_o <= ld_mis;
            state      <= WB_IDLE;
          end
`ifdef WB_TIMEOUT_EN
          else if (to_hit) begin
            timeout_o <= 1'b1;
            state     <= WB_IDLE;
          end
`endif
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule
